// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_reg
//  Purpose  : Valid/ready pipeline register with registered outputs and flush.
//             Define PIPE_STAGE_REG_SKID_EN to add a skid slot, which gives
//             full throughput with a registered in_ready.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    // State codes equal the number of held entries.
    localparam logic [1:0] c_EMPTY = 2'd0;
    localparam logic [1:0] c_ONE   = 2'd1;
`ifdef PIPE_STAGE_REG_SKID_EN
    localparam logic [1:0] c_TWO   = 2'd2;
`endif

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic              w_accept;
    logic              w_consume;
    logic              w_load_in;

    assign w_accept  = in_valid && in_ready;
    assign w_consume = out_valid && out_ready;
    // In ONE without a skid slot, an accept can only happen alongside a consume.
    assign w_load_in = w_accept && ((r_state == c_EMPTY) || w_consume);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = c_EMPTY;
        end else begin
            case (r_state)
                c_EMPTY: begin
                    if (w_accept) begin
                        w_state_next = c_ONE;
                    end
                end
                c_ONE: begin
`ifdef PIPE_STAGE_REG_SKID_EN
                    if (w_accept && !w_consume) begin
                        w_state_next = c_TWO;
                    end else
`endif
                    if (!w_accept && w_consume) begin
                        w_state_next = c_EMPTY;
                    end
                end
`ifdef PIPE_STAGE_REG_SKID_EN
                c_TWO: begin
                    if (w_consume) begin
                        w_state_next = c_ONE;
                    end
                end
`endif
                default: w_state_next = c_EMPTY;
            endcase
        end
    end

`ifdef PIPE_STAGE_REG_SKID_EN
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic              r_in_ready;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else if ((r_state == c_ONE) && w_accept && !w_consume) begin
            r_skid_data <= in_data;
            r_skid_ctrl <= in_ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_ready <= 1'b1;
        end else begin
            r_in_ready <= (w_state_next != c_TWO);
        end
    end
`endif

    // Main slot: ctrl is cleared whenever the stage empties, data is kept.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_main_data <= '0;
            r_main_ctrl <= '0;
        end else if (w_state_next == c_EMPTY) begin
            r_main_ctrl <= '0;
        end else if (w_load_in) begin
            r_main_data <= in_data;
            r_main_ctrl <= in_ctrl;
`ifdef PIPE_STAGE_REG_SKID_EN
        end else if ((r_state == c_TWO) && w_consume) begin
            r_main_data <= r_skid_data;
            r_main_ctrl <= r_skid_ctrl;
`endif
        end
    end

    // Output decode
    always_comb begin
        out_valid = (r_state != c_EMPTY);
        occupancy = r_state;
        out_data  = r_main_data;
        out_ctrl  = r_main_ctrl;
`ifdef PIPE_STAGE_REG_SKID_EN
        in_ready  = r_in_ready;
`else
        in_ready  = (r_state == c_EMPTY) || out_ready;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage_reg
//  Purpose  : Self-checking bench for pipe_stage_reg against a queue model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_REG_SKID_EN
    localparam int c_CAP = 2;
`else
    localparam int c_CAP = 1;
`endif

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  c;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic [1:0]  occupancy;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    ent_t        q[$];
    logic [63:0] last_data = '0;
    bit          model_ok  = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(64), .CTRL_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_in_ready();
        if (c_CAP == 2) return (q.size() < 2);
        return (q.size() == 0) || out_ready;
    endfunction

    // One clock cycle: drive, check against the model, clock, update the model.
    task automatic step(input logic v, input logic [63:0] d, input logic [7:0] c,
                        input logic ordy, input logic fl, input logic rst);
        logic acc, cons;
        ent_t e;
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        #1;
        acc  = 1'b0;
        cons = 1'b0;
        if (model_ok) begin
            chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
            chk("out_data",  out_data, (q.size() != 0) ? q[0].d : last_data);
            chk("out_ctrl",  64'(out_ctrl), (q.size() != 0) ? 64'(q[0].c) : 64'd0);
            chk("occupancy", 64'(occupancy), 64'(q.size()));
            chk("in_ready",  64'(in_ready), 64'(exp_in_ready()));
            acc  = v && exp_in_ready();
            cons = (q.size() != 0) && ordy;
        end
        @(posedge clk);
        if (rst) begin
            q.delete();
            last_data = '0;
            model_ok  = 1;
        end else if (model_ok) begin
            if (q.size() != 0) last_data = q[0].d;
            if (fl) begin
                q.delete();
            end else begin
                if (cons) void'(q.pop_front());
                if (acc) begin
                    e.d = d;
                    e.c = c;
                    q.push_back(e);
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        in_valid = 0; in_data = '0; in_ctrl = '0;
        out_ready = 0; flush = 0; reset = 1;
        @(negedge clk);

        // Reset state
        step(0, 64'd0, 8'd0, 0, 0, 1);
        step(0, 64'd0, 8'd0, 0, 0, 1);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data",  out_data, 64'd0);
        chk("rst_occ",   64'(occupancy), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);

        // Streaming 1..8 with constant out_ready
        for (int i = 1; i <= 8; i++) begin
            step(1, 64'(i), 8'(i), 1, 0, 0);
            chk("stream_data", out_data, 64'(i));
            chk("stream_occ",  64'(occupancy), 64'd1);
        end
        step(0, 64'd0, 8'd0, 1, 0, 0);
        step(0, 64'd0, 8'd0, 1, 0, 0);

        // Backpressure: A accepted, then B, C offered while stalled
        step(1, 64'hA, 8'h01, 1, 0, 0);
        step(1, 64'hB, 8'h02, 0, 0, 0);
`ifdef PIPE_STAGE_REG_SKID_EN
        chk("bp_occ",   64'(occupancy), 64'd2);
        chk("bp_ready", 64'(in_ready), 64'd0);
`endif
        step(1, 64'hC, 8'h03, 0, 0, 0);
        step(1, 64'hC, 8'h03, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 64'hC, 8'h03, 1, 0, 0);
        step(0, 64'd0, 8'd0, 1, 0, 0);
        step(0, 64'd0, 8'd0, 1, 0, 0);

        // Flush with a full stage and an offered entry
        step(1, 64'h1, 8'hFF, 0, 0, 0);
        step(1, 64'h2, 8'hFF, 0, 0, 0);
        step(1, 64'h77, 8'h5A, 0, 1, 0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ctrl",  64'(out_ctrl), 64'd0);
        chk("flush_occ",   64'(occupancy), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
        step(0, 64'd0, 8'd0, 1, 0, 0);
        step(0, 64'd0, 8'd0, 1, 0, 0);

        // Consume, accept and flush in the same cycle
        step(1, 64'h11, 8'h01, 1, 0, 0);
        step(1, 64'h22, 8'h02, 1, 1, 0);
        chk("simul_occ", 64'(occupancy), 64'd0);
        step(0, 64'd0, 8'd0, 1, 0, 0);

        // Reset while full, then first entry afterwards
        step(1, 64'h1, 8'h01, 0, 0, 0);
        step(1, 64'h2, 8'h02, 0, 0, 0);
        step(1, 64'h3, 8'h03, 0, 0, 1);
        chk("rst2_data", out_data, 64'd0);
        chk("rst2_ctrl", 64'(out_ctrl), 64'd0);
        step(1, 64'h44, 8'h04, 1, 0, 0);
        chk("rst2_lat", out_data, 64'h44);
        step(0, 64'd0, 8'd0, 1, 0, 0);

        // Pass-through and stall readiness
        step(1, 64'h5, 8'h05, 0, 0, 0);
        step(1, 64'h6, 8'h06, 1, 0, 0);
        step(1, 64'h7, 8'h07, 0, 0, 0);
        step(1, 64'h7, 8'h07, 0, 0, 0);
        step(0, 64'd0, 8'd0, 1, 0, 0);
        step(0, 64'd0, 8'd0, 1, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, 8'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0),
                 1'($urandom_range(0, 99) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
